pll_lock_sequencer: RTL and testbench

- Controls the video PLL (50 MHz refclk in, 75 MHz pixel clock out) from the refclk domain.
- Drives the PLL's active-high reset and qualifies its lock output: synchronises, debounces, retries on timeout, and latches a fault after repeated failure.
- Publishes a registered `ready` that downstream reset bridges synchronise into the 75 MHz domain.
- Accepts a software/button restart request over a req/ack handshake.

---
 rtl/pll_seq_pkg.sv | 30 +++
 rtl/pll_lock_sequencer_sync.sv | 24 ++
 rtl/pll_lock_sequencer.sv | 147 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL lock sequencer: FSM state encoding,
// default timing constants and width helpers.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 50000;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES    = 3;
  localparam int DEF_SYNC_STAGES    = 2;

  // Width of retry_count: wide enough to hold MAX_RETRIES itself.
  function automatic int retry_w(input int max_retries);
    return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync.sv
// Level-signal synchroniser: STAGES-deep flop chain with async active-low clear.
// Latency is STAGES clk edges; no flow control.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
    end
  end

  assign dout = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Video PLL reset/lock sequencer in the refclk domain: pulses pll_rst, qualifies
// lock, retries on timeout, latches fault; all outputs registered, no backpressure.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic                             refclk,
  input  logic                             rst_n,
  input  logic                             pll_locked,
  output logic                             pll_rst,
  input  logic                             restart_req,
  output logic                             restart_ack,
  output logic                             ready,
  output logic                             fault,
  output logic [retry_w(MAX_RETRIES)-1:0]  retry_count,
  output logic [7:0]                       lost_lock_cnt,
  output logic [2:0]                       state
);

  localparam int RETRY_W = retry_w(MAX_RETRIES);
  localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  state_e             st;
  logic [CNT_W-1:0]   cnt;
  logic               lock_s;
  logic               req_q;
  logic               restart_rise;
  logic [RETRY_W-1:0] retry_next;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .din   (pll_locked),
    .dout  (lock_s)
  );

  // restart_req is a refclk-domain level; only its rising edge is acted on.
  assign restart_rise = restart_req & ~req_q;
  assign retry_next   = retry_count + RETRY_W'(1);
  assign state        = st;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= RESET_PLL;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      ready         <= 1'b0;
      fault         <= 1'b0;
      restart_ack   <= 1'b0;
      retry_count   <= '0;
      lost_lock_cnt <= '0;
      req_q         <= 1'b0;
    end else begin
      req_q       <= restart_req;
      restart_ack <= 1'b0;
      if (restart_rise) begin
        // Restart outranks every other event, including a coincident lock loss.
        st          <= RESET_PLL;
        cnt         <= '0;
        pll_rst     <= 1'b1;
        ready       <= 1'b0;
        fault       <= 1'b0;
        retry_count <= '0;
        restart_ack <= 1'b1;
      end else begin
        case (st)
          RESET_PLL: begin
            if (cnt == RST_LAST) begin
              st      <= WAIT_LOCK;
              cnt     <= '0;
              pll_rst <= 1'b0;
            end else begin
              cnt     <= cnt + CNT_W'(1);
              pll_rst <= 1'b1;
            end
          end
          WAIT_LOCK: begin
            if (lock_s) begin
              st  <= STABILIZE;
              cnt <= '0;
            end else if (cnt == TIMEOUT_LAST) begin
              retry_count <= retry_next;
              cnt         <= '0;
              pll_rst     <= 1'b1;
              if (retry_next == RETRY_LIMIT) begin
                st    <= FAULT;
                fault <= 1'b1;
                ready <= 1'b0;
              end else begin
                st <= RESET_PLL;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          STABILIZE: begin
            if (!lock_s) begin
              st  <= WAIT_LOCK;
              cnt <= '0;
            end else if (cnt == STABLE_LAST) begin
              st          <= RUN;
              cnt         <= '0;
              ready       <= 1'b1;
              retry_count <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RUN: begin
            if (!lock_s) begin
              st      <= RESET_PLL;
              cnt     <= '0;
              pll_rst <= 1'b1;
              ready   <= 1'b0;
              if (lost_lock_cnt != 8'hFF) begin
                lost_lock_cnt <= lost_lock_cnt + 8'd1;
              end
            end
          end
          FAULT: begin
            pll_rst <= 1'b1;
            fault   <= 1'b1;
            ready   <= 1'b0;
          end
          default: begin
            st      <= RESET_PLL;
            cnt     <= '0;
            pll_rst <= 1'b1;
            ready   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters; expected
// values are queued when stimulus is applied and compared when the DUT responds.
module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       restart_req;
  logic       pll_rst;
  logic       restart_ack;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] lost_lock_cnt;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  pll_lock_sequencer #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (20),
    .STABLE_CYCLES  (8),
    .MAX_RETRIES    (2),
    .SYNC_STAGES    (2)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .restart_req   (restart_req),
    .restart_ack   (restart_ack),
    .ready         (ready),
    .fault         (fault),
    .retry_count   (retry_count),
    .lost_lock_cnt (lost_lock_cnt),
    .state         (state)
  );

  always #5 refclk = ~refclk;

  function automatic logic sig(input int which);
    case (which)
      0:       return pll_rst;
      1:       return ready;
      2:       return fault;
      default: return restart_ack;
    endcase
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %0d expected an entry", obs);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  // Negedges until the signal reaches v; -1 if the budget runs out.
  task automatic wait_level(input int which, input logic v, input int budget, output int n);
    n = 0;
    while (sig(which) !== v && n < budget) begin
      @(negedge refclk);
      n++;
    end
    if (sig(which) !== v) n = -1;
  endtask

  // Consecutive negedge samples (including the current one) at level v.
  task automatic run_len(input int which, input logic v, input int budget, output int n);
    n = 0;
    while (sig(which) === v && n < budget) begin
      n++;
      @(negedge refclk);
    end
  endtask

  initial begin
    int n;
    int acks;
    int done;

    rst_n       = 1'b0;
    pll_locked  = 1'b0;
    restart_req = 1'b0;
    repeat (3) @(negedge refclk);

    // Reset state
    push("rst_state", 0);   check(state);
    push("rst_pll_rst", 1); check(pll_rst);
    push("rst_ready", 0);   check(ready);
    push("rst_fault", 0);   check(fault);
    push("rst_ack", 0);     check(restart_ack);
    push("rst_retry", 0);   check(retry_count);
    push("rst_lost", 0);    check(lost_lock_cnt);

    // Clean lock
    rst_n = 1'b1;
    push("first_rst_pulse", 4);
    run_len(0, 1'b1, 40, n); check(n);
    repeat (3) @(negedge refclk);
    pll_locked = 1'b1;
    push("lock_to_ready", 11);
    wait_level(1, 1'b1, 100, n); check(n);
    push("run_retry", 0); check(retry_count);
    push("run_state", 3); check(state);

    // Lock loss in RUN
    pll_locked = 1'b0;
    push("loss_to_ready_low", 3);
    wait_level(1, 1'b0, 20, n); check(n);
    push("loss_lost_cnt", 1);  check(lost_lock_cnt);
    push("loss_state", 0);     check(state);
    push("loss_pll_rst", 1);   check(pll_rst);
    push("loss_rst_pulse", 4);
    run_len(0, 1'b1, 40, n); check(n);

    // One timeout
    push("wait_window_a", 20);
    run_len(0, 1'b0, 100, n); check(n);
    push("retry_after_timeout", 1); check(retry_count);
    push("retry_rst_pulse", 4);
    run_len(0, 1'b1, 40, n); check(n);

    // Glitch in STABILIZE
    pll_locked = 1'b1;
    repeat (5) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    @(negedge refclk);
    push("glitch_in_stabilize", 2); check(state);
    @(negedge refclk);
    push("glitch_back_to_wait", 1); check(state);
    push("glitch_retry_kept", 1);   check(retry_count);
    push("relock_to_ready", 9);
    wait_level(1, 1'b1, 100, n); check(n);
    push("relock_retry_clear", 0); check(retry_count);

    // Timeouts into FAULT
    pll_locked = 1'b0;
    push("loss2_to_ready_low", 3);
    wait_level(1, 1'b0, 20, n); check(n);
    push("loss2_lost_cnt", 2); check(lost_lock_cnt);
    push("loss2_rst_pulse", 4);
    run_len(0, 1'b1, 40, n); check(n);
    push("wait_window_b", 20);
    run_len(0, 1'b0, 100, n); check(n);
    push("retry1_rst_pulse", 4);
    run_len(0, 1'b1, 40, n); check(n);
    push("wait_window_c", 20);
    run_len(0, 1'b0, 100, n); check(n);
    push("fault_state", 4);   check(state);
    push("fault_flag", 1);    check(fault);
    push("fault_pll_rst", 1); check(pll_rst);
    push("fault_retry", 2);   check(retry_count);
    push("fault_ready", 0);   check(ready);
    repeat (5) @(negedge refclk);
    push("fault_sticky", 4);  check(state);

    // Restart from FAULT with a held request
    restart_req = 1'b1;
    @(negedge refclk);
    push("restart_ack", 1);   check(restart_ack);
    push("restart_state", 0); check(state);
    push("restart_fault", 0); check(fault);
    push("restart_retry", 0); check(retry_count);
    acks = int'(restart_ack);
    repeat (9) begin
      @(negedge refclk);
      acks += int'(restart_ack);
    end
    push("ack_pulse_count", 1); check(acks);
    restart_req = 1'b0;
    pll_locked  = 1'b1;
    push("restart_relock", 11);
    wait_level(1, 1'b1, 100, n); check(n);

    // Restart edge coincident with lock loss in RUN
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    restart_req = 1'b1;
    @(negedge refclk);
    push("corner_ack", 1);       check(restart_ack);
    push("corner_lost_cnt", 2);  check(lost_lock_cnt);
    push("corner_ready", 0);     check(ready);
    push("corner_state", 0);     check(state);
    restart_req = 1'b0;

    // Saturation of lost_lock_cnt
    done = 0;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      wait_level(1, 1'b1, 60, n);
      if (n < 0) break;
      pll_locked = 1'b0;
      wait_level(1, 1'b0, 10, n);
      if (n < 0) break;
      done++;
    end
    push("loss_loop_done", 300); check(done);
    push("lost_cnt_saturated", 255); check(lost_lock_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
